// File: rtl/count_checker_pkg.sv
// count_checker_pkg
//   Shared definitions for the counter-consistency monitor:
//   - state_e   : monitor FSM states (IDLE/ACQUIRE/LOCKED, encoded 00/01/10)
//   - DEF_*     : default values for the count_checker parameters
//   - RUN_W     : width of the consecutive-good-sample run counter
package count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 2;
  localparam int DEF_ERR_W    = 8;

  // The run counter only has to reach LOCK_CNT, which is at most 15.
  localparam int RUN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   W-bit saturating up-counter with synchronous clear.
//   Ports:
//     clk      : clock
//     rstn     : asynchronous active-low reset, clears the count
//     inc_i    : count one event this cycle
//     clr_i    : synchronous clear
//     count_o  : current count (registered)
//   inc_i wins over clr_i: a clear that coincides with an event leaves the
//   count at 1, so the event that happened during the clear is not lost.
module sat_counter
  import count_checker_pkg::*;
#(
  parameter int W = DEF_ERR_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if (clr_i) begin
        count_d = W'(1);
      end else if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
    end else if (clr_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_checker.sv
// count_checker
//   Monitors two free-running WIDTH-bit up-counters that should produce the
//   same sequence. It locks onto their common sequence, predicts the next
//   value and flags every divergence.
//   Ports:
//     clk        : clock; cnt_a/cnt_b are sampled on its rising edge
//     rstn       : asynchronous active-low reset
//     check_en   : enables checking; low returns the monitor to IDLE
//     cnt_a      : value of counter A
//     cnt_b      : value of counter B
//     clr_err    : synchronous clear of err_sticky and err_count
//     locked     : high while the monitor is locked onto the sequence
//     mismatch   : one-cycle pulse per detected divergence
//     err_sticky : set by any divergence, cleared by rstn or clr_err
//     err_count  : saturating count of divergences
//     wrap_pulse : one-cycle pulse when a matched sample is all-ones
//   All outputs are registered; the result for the values sampled at an edge
//   is visible from that edge until the next one.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             check_en,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               exp_valid_q, exp_valid_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               mismatch_q, mismatch_d;
  logic               wrap_q, wrap_d;
  logic               sticky_q, sticky_d;
  logic               err_event;

  logic               acq_good;
  logic [RUN_W-1:0]   run_inc;
  logic               both_match;

  // In ACQUIRE a sample only counts once a prediction exists; the first
  // edge after entering ACQUIRE merely seeds exp.
  assign acq_good   = exp_valid_q && (cnt_a == cnt_b) && (cnt_a == exp_q);
  assign run_inc    = run_q + 1'b1;
  assign both_match = (cnt_a == exp_q) && (cnt_b == exp_q);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    exp_valid_d = exp_valid_q;
    run_d       = run_q;
    locked_d    = 1'b0;
    mismatch_d  = 1'b0;
    wrap_d      = 1'b0;
    err_event   = 1'b0;

    if (!check_en) begin
      // Disabling overrides every other transition.
      state_d     = IDLE;
      exp_valid_d = 1'b0;
      run_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = ACQUIRE;
          exp_valid_d = 1'b0;
          run_d       = '0;
        end

        ACQUIRE: begin
          exp_d       = cnt_a + 1'b1;
          exp_valid_d = 1'b1;
          if (acq_good) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end

        LOCKED: begin
          if (both_match) begin
            exp_d    = exp_q + 1'b1;
            wrap_d   = &exp_q;
            locked_d = 1'b1;
          end else begin
            mismatch_d  = 1'b1;
            err_event   = 1'b1;
            state_d     = ACQUIRE;
            run_d       = '0;
            exp_valid_d = 1'b0;
          end
        end

        default: begin
          state_d     = IDLE;
          exp_valid_d = 1'b0;
          run_d       = '0;
        end
      endcase
    end
  end

  // A new error overrides a coincident clear so that it is never lost.
  always_comb begin
    sticky_d = sticky_q;
    if (err_event) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      exp_valid_q <= 1'b0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      wrap_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      wrap_q      <= wrap_d;
      sticky_q    <= sticky_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_count (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (err_event),
    .clr_i   (clr_err),
    .count_o (err_count)
  );

  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign wrap_pulse = wrap_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker
//   Directed bench for count_checker. Two instances share all inputs: one
//   with default parameters and one with ERR_W = 2 for saturation. The
//   counter values are driven directly; each step applies one sample and
//   inspects the registered outputs 1 time unit after the clock edge.
module tb_count_checker;

  logic       clk;
  logic       rstn;
  logic       check_en;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       clr_err;

  logic       locked, mismatch, err_sticky, wrap_pulse;
  logic [7:0] err_count;
  logic       s_locked, s_mismatch, s_err_sticky, s_wrap_pulse;
  logic [1:0] s_err_count;

  int n_checks = 0;
  int n_errors = 0;
  int wrap_seen = 0;
  int s_mism_seen = 0;
  logic [3:0] v;

  count_checker dut (
    .clk        (clk),
    .rstn       (rstn),
    .check_en   (check_en),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .clr_err    (clr_err),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse)
  );

  count_checker #(
    .WIDTH    (4),
    .LOCK_CNT (2),
    .ERR_W    (2)
  ) dut_sat (
    .clk        (clk),
    .rstn       (rstn),
    .check_en   (check_en),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .clr_err    (clr_err),
    .locked     (s_locked),
    .mismatch   (s_mismatch),
    .err_sticky (s_err_sticky),
    .err_count  (s_err_count),
    .wrap_pulse (s_wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Apply one sample and wait until just after the edge that takes it.
  task automatic step(input logic [3:0] a, input logic [3:0] b);
    cnt_a = a;
    cnt_b = b;
    @(posedge clk);
    #1;
    if (wrap_pulse) wrap_seen++;
    if (s_mismatch) s_mism_seen++;
    $display("t=%0t a=%0h b=%0h locked=%0b mism=%0b wrap=%0b sticky=%0b cnt=%0d",
             $time, a, b, locked, mismatch, wrap_pulse, err_sticky, err_count);
  endtask

  // Clean counting while locked; wrap expected exactly on the value-F sample.
  task automatic run_ok(input int n);
    for (int i = 0; i < n; i++) begin
      v = v + 4'd1;
      step(v, v);
      check("run_mismatch", mismatch, 0);
      check("run_locked", locked, 1);
      check("run_wrap", wrap_pulse, (v == 4'hF) ? 1 : 0);
    end
  endtask

  // Re-acquisition from value s: seed, good, good -> locked on the third edge.
  task automatic relock(input logic [3:0] s);
    v = s;
    step(v, v);
    check("relock_seed_locked", locked, 0);
    check("relock_seed_mism", mismatch, 0);
    v = v + 4'd1;
    step(v, v);
    check("relock_run1_locked", locked, 0);
    v = v + 4'd1;
    step(v, v);
    check("relock_locked", locked, 1);
    check("relock_mism", mismatch, 0);
  endtask

  // One corrupted cnt_b sample while locked, then relock on the next values.
  task automatic inject;
    v = v + 4'd1;
    step(v, v + 4'd3);
    check("inj_mismatch", mismatch, 1);
    check("inj_locked", locked, 0);
    relock(v + 4'd1);
  endtask

  initial begin
    rstn     = 1'b0;
    check_en = 1'b0;
    clr_err  = 1'b0;
    cnt_a    = 4'd0;
    cnt_b    = 4'd0;
    v        = 4'd0;

    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_count", err_count, 0);
    check("rst_wrap", wrap_pulse, 0);

    // Clean lock. The counters come out of reset one cycle after the
    // monitor, so the IDLE->ACQUIRE edge and the first ACQUIRE edge both see 0.
    check_en = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step(4'd0, 4'd0);
    check("idle_exit_locked", locked, 0);
    v = 4'd0;
    step(v, v);
    check("acq_seed_locked", locked, 0);
    v = 4'd1;
    step(v, v);
    check("acq_run1_locked", locked, 0);
    v = 4'd2;
    step(v, v);
    check("lock_after_2", locked, 1);
    check("lock_mismatch", mismatch, 0);

    wrap_seen = 0;
    run_ok(40);                    // values 3..F,0..F,0..A
    check("wrap_count_40", wrap_seen, 2);

    // Single glitch: cnt_b = 7 when 5 is expected.
    run_ok(10);                    // v = 4
    v = 4'd5;
    step(4'd5, 4'd7);
    check("glitch_mismatch", mismatch, 1);
    check("glitch_count", err_count, 1);
    check("glitch_sticky", err_sticky, 1);
    check("glitch_locked", locked, 0);
    relock(4'd6);                  // 6,7,8 -> locked
    v = v + 4'd1;
    step(v, v);
    check("glitch_one_pulse", mismatch, 0);

    // Counter reset at value 9: counters show 0 for two edges, then 1, 2.
    step(4'd0, 4'd0);
    check("crst_mismatch", mismatch, 1);
    check("crst_count", err_count, 2);
    check("crst_locked", locked, 0);
    relock(4'd0);
    run_ok(1);                     // 3 matches, no second mismatch

    // clr_err with no error.
    clr_err = 1'b1;
    v = v + 4'd1;
    step(v, v);
    clr_err = 1'b0;
    check("clr_count", err_count, 0);
    check("clr_sticky", err_sticky, 0);
    check("clr_locked", locked, 1);

    // clr_err coinciding with an error: the error wins.
    clr_err = 1'b1;
    v = v + 4'd1;
    step(v, v + 4'd3);
    clr_err = 1'b0;
    check("clr_err_count", err_count, 1);
    check("clr_err_sticky", err_sticky, 1);
    check("clr_err_mism", mismatch, 1);
    relock(v + 4'd1);

    // Saturation with ERR_W = 2 after a clean clear.
    clr_err = 1'b1;
    v = v + 4'd1;
    step(v, v);
    clr_err = 1'b0;
    check("sat_pre_clear", s_err_count, 0);
    s_mism_seen = 0;
    for (int k = 0; k < 5; k++) inject();
    check("sat_count", s_err_count, 3);
    check("sat_pulses", s_mism_seen, 5);
    check("sat_wide_count", err_count, 5);
    check("sat_sticky", s_err_sticky, 1);

    // Drop check_en while locked.
    check_en = 1'b0;
    v = v + 4'd1;
    step(v, v);
    check("dis_locked", locked, 0);
    check("dis_count", err_count, 5);
    check("dis_sticky", err_sticky, 1);
    step(v, v + 4'd5);             // divergence while idle is ignored
    check("dis_idle_mism", mismatch, 0);
    check("dis_idle_count", err_count, 5);

    // Re-enable and relock before the asynchronous reset.
    check_en = 1'b1;
    v = v + 4'd1;
    step(v, v);
    relock(v + 4'd1);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_count", err_count, 0);
    check("arst_sticky", err_sticky, 0);
    check("arst_sat_count", s_err_count, 0);
    check("arst_mismatch", mismatch, 0);
    check("arst_wrap", wrap_pulse, 0);
    @(negedge clk);
    rstn = 1'b1;
    v = v + 4'd1;
    step(v, v);
    check("post_arst_locked", locked, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Self-checking monitor for free-running WIDTH-bit up-counters. It sits on the consuming side of the counter block's output bus. It watches two counter implementations driven by the same clock and reset (for example, a synchronous counter and a ripple counter). It locks onto their common sequence, predicts the next value, and reports every divergence as an error pulse, a sticky flag and a saturating error count. It is synthesizable and is used both in benches and as an on-chip sanity monitor.

## Interface
- WIDTH, 4: width of the monitored counters.
- LOCK_CNT, 2: consecutive correct increments required to lock (1..15).
- ERR_W, 8: width of the error counter.

- clk  in  1  single clock; samples cnt_a/cnt_b on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- check_en  in  1  high enables checking; low forces IDLE.
- cnt_a  in  WIDTH  output of counter A.
- cnt_b  in  WIDTH  output of counter B.
- clr_err  in  1  synchronous clear of err_sticky and err_count.
- locked  out  1  high while in LOCKED.
- mismatch  out  1  one-cycle pulse per detected error.
- err_sticky  out  1  set by any error; cleared by rstn or clr_err.
- err_count  out  ERR_W  saturating count of errors.
- wrap_pulse  out  1  one-cycle pulse when a matched sample equals all-ones in LOCKED.

## Operation
- Reset state: all outputs 0, state IDLE, exp = 0, run = 0.
- States:
  - IDLE: entered from any state when check_en = 0. Outputs mismatch, locked and wrap_pulse are 0. err_sticky and err_count are held.
  - ACQUIRE:
    - Each edge: exp <= cnt_a + 1 (mod 2^WIDTH).
    - A sample is good if exp_valid && cnt_a == cnt_b && cnt_a == exp. Good samples increment run; any other sample sets run to 0.
    - The first edge after entry only loads exp (exp_valid <= 1) and is never good.
    - When run reaches LOCK_CNT, go to LOCKED; locked rises on that same edge.
    - No errors are counted in ACQUIRE.
  - LOCKED: each edge compares cnt_a and cnt_b against exp.
    - Both equal: exp <= exp + 1 (modular; wraps from 2^WIDTH-1 to 0). wrap_pulse = 1 if exp was all-ones.
    - Either differs: mismatch = 1, err_sticky = 1, err_count increments (saturating at 2^ERR_W-1). Go to ACQUIRE with run = 0 and exp_valid = 0; locked falls on that edge.
- Transitions: IDLE -> ACQUIRE when check_en = 1. ACQUIRE/LOCKED -> IDLE when check_en = 0; this has priority over everything else.
- A reset of the monitored counters mid-run (value jumps to 0) counts as exactly one mismatch, followed by reacquisition.
- clr_err coinciding with a new error: the error wins, giving err_sticky = 1 and err_count = 1.
- Arithmetic: exp and compare are WIDTH bits, unsigned and modular. run is 4 bits.

## Timing
- All outputs are registered. A result for the values sampled at edge k is visible from edge k until edge k+1.
- Lock latency: locked is high LOCK_CNT+1 edges after the first sample in ACQUIRE, given a clean sequence.
- mismatch and wrap_pulse are high for exactly one cycle per event.
- Asynchronous rstn assertion clears all state immediately, mid-operation included. Release is sampled at the next clk rise.
- check_en falling: locked is low after the next edge.

## Structure
- Package count_checker_pkg holds:
  - state enum IDLE/ACQUIRE/LOCKED (2-bit encoding 00/01/10).
  - default parameter constants.
- One natural sub-module: sat_counter (ERR_W wide, with inc and clr inputs, inc has priority), instantiated for err_count.
- The rest is one FSM process plus the exp/run registers.

## Test plan
- Clean lock: rstn low for 5 cycles; both counters count from 0; check_en = 1.
  - locked rises after the edge sampling value 2.
  - No mismatch within 40 cycles.
  - wrap_pulse fires once per 16 cycles, on the value-F sample.
- Single glitch: force cnt_b = 7 when 5 is expected, for one cycle.
  - mismatch pulses once; err_count = 1; err_sticky = 1; locked drops.
  - locked relocks 3 edges later.
- Counter reset mid-run: pulse the counters' reset at value 9.
  - Exactly one mismatch; err_count increments by 1; relock on the 0,1,2 sequence.
- Saturation: ERR_W = 2; inject 5 separate errors.
  - err_count holds at 3; 5 mismatch pulses observed.
- clr_err: assert with no error, then with a coincident error.
  - First case: err_count = 0 and err_sticky = 0.
  - Second case: err_count = 1 and err_sticky = 1.
- check_en and async reset:
  - Drop check_en while locked: locked = 0 next cycle; counts are held.
  - Assert rstn between clock edges: all outputs go to 0 immediately.
